// File: rtl/sine_capture.sv
// Trigger-aligned capture of {din, din2} sample pairs from the sine generator,
// replayed afterwards as a valid/ready stream of DEPTH beats.
module sine_capture #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   din,
  input  logic [WIDTH-1:0]   din2,
  input  logic [WIDTH-1:0]   trig_level,
  input  logic               arm,
  output logic               busy,
  output logic               done,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [2*WIDTH-1:0] rd_data,
  output logic               rd_last,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, READOUT} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]   prev;
  logic               prev_ok;
  logic [AW-1:0]      wptr;
  logic [AW-1:0]      rptr;
  logic [2*WIDTH-1:0] mem [DEPTH];

  logic               trig_hit;
  logic               wr_en;
  logic [AW-1:0]      wr_addr;
  logic [AW-1:0]      rd_addr;
  logic               load_beat;
  logic               accept;
  logic               last_beat;

  // Readout handshake: a beat transfers on any edge where rd_valid && rd_ready.
  // Once rd_valid is high it stays high, with rd_data/rd_last frozen, until accepted.
  always_comb begin
    state_nxt = state;
    trig_hit  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = wptr;
    rd_addr   = rptr;
    load_beat = 1'b0;
    accept    = rd_valid && rd_ready;
    last_beat = accept && (rptr == AW'(DEPTH - 1));
    case (state)
      IDLE: begin
        if (arm) state_nxt = ARMED;
      end
      ARMED: begin
        if (en && prev_ok && (prev < trig_level) && (din >= trig_level)) begin
          trig_hit  = 1'b1;
          wr_en     = 1'b1;
          wr_addr   = '0;
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        if (en) begin
          wr_en = 1'b1;
          if (wptr == AW'(DEPTH - 1)) state_nxt = READOUT;
        end
      end
      READOUT: begin
        // First cycle in READOUT fetches entry 0; later fetches run one entry ahead
        // so back-to-back acceptances see no bubble.
        if (!rd_valid) begin
          load_beat = 1'b1;
        end else if (accept && !last_beat) begin
          load_beat = 1'b1;
          rd_addr   = rptr + 1'b1;
        end
        if (last_beat) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev     <= '0;
      prev_ok  <= 1'b0;
      wptr     <= '0;
      rptr     <= '0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            prev_ok <= 1'b0;
            wptr    <= '0;
          end
        end
        ARMED: begin
          if (en) begin
            prev    <= din;
            prev_ok <= 1'b1;
          end
          if (trig_hit) wptr <= AW'(1);
        end
        CAPTURE: begin
          if (en) begin
            wptr <= wptr + 1'b1;
            if (wptr == AW'(DEPTH - 1)) rptr <= '0;
          end
        end
        READOUT: begin
          if (load_beat) begin
            rd_valid <= 1'b1;
            rd_last  <= (rd_addr == AW'(DEPTH - 1));
            rptr     <= rd_addr;
          end else if (last_beat) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Storage is deliberately left uncleared by reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= {din, din2};
  end

  always_ff @(posedge clk) begin
    if (rst)            rd_data <= '0;
    else if (load_beat) rd_data <= mem[rd_addr];
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule
